cv32e40x_mul_arbiter: RTL and testbench
=======================================

Name: cv32e40x_mul_arbiter

Overview:
Shares one cv32e40x_mult instance between two requesters: requester 0 is the EX-stage pipeline and requester 1 is an auxiliary/offload unit. Each requester uses the same valid/ready/halt/kill protocol as the multiplier. The arbiter picks an owner combinationally, so a single-cycle MUL adds no latency. It locks the owner for the whole multi-cycle MULH sequence, and it forwards halt/kill only from the owner.

Parameters:
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  [1:0]  per-requester operation valid
req_operator_i  in  [1:0] x mul_opcode_e  per-requester MUL_M32 / MUL_H
req_signed_mode_i  in  [1:0][1:0]  per-requester signed mode
req_op_a_i  in  [1:0][31:0]  operand A
req_op_b_i  in  [1:0][31:0]  operand B
req_halt_i  in  [1:0]  per-requester halt
req_kill_i  in  [1:0]  per-requester kill
req_ready_i  in  [1:0]  requester accepts result
req_ready_o  out  [1:0]  operation consumed / requester may advance
req_valid_o  out  [1:0]  result valid to requester
req_result_o  out  [1:0][31:0]  result
mul_valid_o  out  1  to mult valid_i
mul_operator_o  out  mul_opcode_e  to mult operator_i
mul_signed_mode_o  out  2  to mult signed_mode_i
mul_op_a_o  out  32  to mult op_a_i
mul_op_b_o  out  32  to mult op_b_i
mul_halt_o  out  1  to mult halt_i
mul_kill_o  out  1  to mult kill_i
mul_ready_o  out  1  to mult ready_i
mul_ready_i  in  1  from mult ready_o
mul_valid_i  in  1  from mult valid_o
mul_result_i  in  32  from mult result_o

Clock is clk; reset is rst_n, asynchronous and active-low.

Behaviour:
- State flops: state (ARB_IDLE/ARB_BUSY), owner (1 bit), last_grant (1 bit).
- Reset values: state=ARB_IDLE, owner=0, last_grant=1 (requester 0 wins first under RR).
- Outputs during and after reset with no valid input: all req_valid_o=0, req_ready_o=0 except killed requesters, mul_valid_o=0, mul_kill_o=0.

Grant selection:
- ARB_IDLE: sel = winner among requesters with req_valid_i && !req_kill_i.
  - RR_EN=1: prefer !last_grant when both request.
  - RR_EN=0: requester 0 wins when both request.
  - With no candidate, sel=0 and mul_valid_o=0.
- ARB_BUSY: sel = owner, regardless of the other requester.

Datapath:
- mul_* operand, operator, signed_mode, valid, halt and kill outputs come from requester sel.
- mul_ready_o = req_ready_i[sel].
- req_result_o[i] = mul_result_i for both requesters; req_valid_o[sel] = mul_valid_i.

Handshake for the requester that is not sel:
- req_valid_o=0 and req_ready_o=0 (stalled).
- Exception: if it is killed, req_ready_o=1 with no effect on the multiplier.
- req_ready_o[sel] = mul_ready_i.

Completion:
- done = mul_valid_o && !mul_halt_o && mul_ready_i, or req_kill_i[sel].

Transitions:
- IDLE -> BUSY when a candidate exists and !done; owner<=sel.
- IDLE stays IDLE when done in the same cycle (single-cycle MUL accepted); last_grant<=sel.
- BUSY -> IDLE on done; last_grant<=owner.
- Halted owner: no state change, and the other requester stays blocked.

Boundary conditions:
- Simultaneous requests in IDLE: arbitration rule above.
- A new request arriving while BUSY waits; it is never dropped.
- Kill of the owner mid-MULH: mul_kill_o=1, and the arbiter returns to IDLE in the same cycle the multiplier resets its FSM. The other requester may be granted on the next cycle.
- Owner deasserting req_valid_i while BUSY without kill is a protocol violation; an assertion fires.
- Asynchronous reset mid-MULH returns to IDLE. The multiplier is reset in the same domain.
- mul_valid_i=1 while mul_valid_o=0 never occurs; an assertion covers this.

Decomposition:
- Add to cv32e40x_pkg:
  - mul_arb_state_e {ARB_IDLE, ARB_BUSY}
  - localparam MUL_ARB_NUM_REQ = 2
  - mul_req_t struct {valid, operator, signed_mode, op_a, op_b, halt, kill}
- Sub-module cv32e40x_rr_arb2: a combinational 2-way round-robin/fixed-priority picker taking req[1:0], last_grant and RR_EN, returning sel and any.

Test Plan:
- Both requesters valid in IDLE after reset with RR_EN=1, MUL 3*5 and 7*9 -> cycle 0 result 15 to requester 0; cycle 1 result 63 to requester 1.
- Requester 1 issues MULH 0x80000000*0x80000000, and requester 0 requests MUL in cycle 1 -> requester 1 gets 0x40000000 on cycle 3; requester 0 ready_o=0 in cycles 1-3 and is granted in cycle 4.
- Owner requester 0 doing MULHU 0xFFFFFFFF*0xFFFFFFFF is killed in cycle 2 -> mul_kill_o=1; requester 1's pending MUL 2*2 is granted in cycle 3 with result 4, not corrupted by the stale accumulator.
- Owner halted for 5 cycles mid-MULH -> no state advance and requester 1 blocked; after release, the result matches the unhalted value of 0xFFFFFFFE for MULHU 0xFFFFFFFF*0xFFFFFFFF.
- With RR_EN=0, requester 0 issues back-to-back MULs for 10 cycles while requester 1 is valid -> requester 1 is never granted until requester 0 idles.
- req_ready_i[owner]=0 at completion of MUL 6*7 -> req_valid_o=1 with result 42 held stable and BUSY persists until ready.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared multiplier opcodes and multiplier-arbiter types

package cv32e40x_pkg;

    typedef enum logic [0:0] {
        MUL_M32 = 1'b0,
        MUL_H   = 1'b1
    } mul_opcode_e;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } mul_arb_state_e;

    localparam int MUL_ARB_NUM_REQ = 2;

    typedef struct packed {
        logic        valid;
        mul_opcode_e operator;
        logic [1:0]  signed_mode;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic        halt;
        logic        kill;
    } mul_req_t;

endpackage

// File: rtl/cv32e40x_rr_arb2.sv
// rtl/cv32e40x_rr_arb2.sv - combinational 2-way round-robin / fixed-priority picker

module cv32e40x_rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       sel,
    output logic       any
);

    always_comb begin
        any = |req;
        sel = 1'b0;
        if (req == 2'b11) begin
            sel = RR_EN ? ~last_grant : 1'b0;
        end else begin
            sel = req[1];
        end
    end

endmodule

// File: rtl/cv32e40x_mul_arbiter.sv
// rtl/cv32e40x_mul_arbiter.sv - shares one multiplier between the EX stage and an offload requester

module cv32e40x_mul_arbiter
    import cv32e40x_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic        [MUL_ARB_NUM_REQ-1:0]         req_valid_i,
    input  mul_opcode_e [MUL_ARB_NUM_REQ-1:0]         req_operator_i,
    input  logic        [MUL_ARB_NUM_REQ-1:0][1:0]    req_signed_mode_i,
    input  logic        [MUL_ARB_NUM_REQ-1:0][31:0]   req_op_a_i,
    input  logic        [MUL_ARB_NUM_REQ-1:0][31:0]   req_op_b_i,
    input  logic        [MUL_ARB_NUM_REQ-1:0]         req_halt_i,
    input  logic        [MUL_ARB_NUM_REQ-1:0]         req_kill_i,
    input  logic        [MUL_ARB_NUM_REQ-1:0]         req_ready_i,
    output logic        [MUL_ARB_NUM_REQ-1:0]         req_ready_o,
    output logic        [MUL_ARB_NUM_REQ-1:0]         req_valid_o,
    output logic        [MUL_ARB_NUM_REQ-1:0][31:0]   req_result_o,
    output logic                                      mul_valid_o,
    output mul_opcode_e                               mul_operator_o,
    output logic        [1:0]                         mul_signed_mode_o,
    output logic        [31:0]                        mul_op_a_o,
    output logic        [31:0]                        mul_op_b_o,
    output logic                                      mul_halt_o,
    output logic                                      mul_kill_o,
    output logic                                      mul_ready_o,
    input  logic                                      mul_ready_i,
    input  logic                                      mul_valid_i,
    input  logic        [31:0]                        mul_result_i
);

    mul_arb_state_e state_q, state_n;
    logic           owner_q, owner_n;
    logic           last_grant_q, last_grant_n;

    mul_req_t                   req [MUL_ARB_NUM_REQ];
    logic [MUL_ARB_NUM_REQ-1:0] cand;
    logic                       pick, any, sel, grant, done;

    always_comb begin
        for (int i = 0; i < MUL_ARB_NUM_REQ; i++) begin
            req[i] = '{valid:       req_valid_i[i],
                       operator:    req_operator_i[i],
                       signed_mode: req_signed_mode_i[i],
                       op_a:        req_op_a_i[i],
                       op_b:        req_op_b_i[i],
                       halt:        req_halt_i[i],
                       kill:        req_kill_i[i]};
            cand[i] = req_valid_i[i] && !req_kill_i[i];
        end
    end

    cv32e40x_rr_arb2 #(.RR_EN(RR_EN)) u_rr_arb2 (
        .req        (cand),
        .last_grant (last_grant_q),
        .sel        (pick),
        .any        (any)
    );

    // Once a multi-cycle MULH has started the owner keeps the multiplier until done.
    assign sel   = (state_q == ARB_BUSY) ? owner_q : pick;
    assign grant = (state_q == ARB_BUSY) || any;

    assign mul_valid_o       = grant && req[sel].valid;
    assign mul_operator_o    = req[sel].operator;
    assign mul_signed_mode_o = req[sel].signed_mode;
    assign mul_op_a_o        = req[sel].op_a;
    assign mul_op_b_o        = req[sel].op_b;
    assign mul_halt_o        = req[sel].halt;
    assign mul_kill_o        = grant && req[sel].kill;
    assign mul_ready_o       = req_ready_i[sel];

    assign done = (mul_valid_o && !mul_halt_o && mul_ready_i) || mul_kill_o;

    // A killed requester that does not hold the multiplier is released locally.
    always_comb begin
        req_ready_o = req_kill_i;
        req_valid_o = '0;
        if (grant) begin
            req_ready_o[sel] = mul_ready_i;
            req_valid_o[sel] = mul_valid_i;
        end
    end

    assign req_result_o = {MUL_ARB_NUM_REQ{mul_result_i}};

    always_comb begin
        state_n      = state_q;
        owner_n      = owner_q;
        last_grant_n = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    if (done) begin
                        last_grant_n = sel;
                    end else begin
                        state_n = ARB_BUSY;
                        owner_n = sel;
                    end
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    state_n      = ARB_IDLE;
                    last_grant_n = owner_q;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            last_grant_q <= last_grant_n;
        end
    end

    a_owner_holds_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ARB_BUSY) |-> (req_valid_i[owner_q] || req_kill_i[owner_q]));

    a_no_unrequested_result: assert property (@(posedge clk) disable iff (!rst_n)
        mul_valid_i |-> mul_valid_o);

endmodule

// File: tb/tb_cv32e40x_mul_arbiter.sv
// tb/tb_cv32e40x_mul_arbiter.sv - directed bench for the multiplier arbiter with a behavioural multiplier

module tb_cv32e40x_mul_arbiter;
    import cv32e40x_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        [1:0]       req_valid, req_halt, req_kill, req_ready;
    mul_opcode_e [1:0]       req_operator;
    logic        [1:0][1:0]  req_sm;
    logic        [1:0][31:0] req_a, req_b;

    // Outputs of the round-robin instance (rr) and fixed-priority instance (fp)
    logic [1:0]       rr_rdy, rr_vld, fp_rdy, fp_vld;
    logic [1:0][31:0] rr_res, fp_res;
    logic             rr_mv, rr_mh, rr_mk, rr_mr, fp_mv, fp_mh, fp_mk, fp_mr;
    mul_opcode_e      rr_mop, fp_mop;
    logic [1:0]       rr_msm, fp_msm;
    logic [31:0]      rr_ma, rr_mb, fp_ma, fp_mb;
    logic [33:0]      rr_m, fp_m;
    logic [1:0]       rr_cnt, fp_cnt;

    int total = 0;
    int bad   = 0;

    cv32e40x_mul_arbiter #(.RR_EN(1'b1)) u_dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_operator_i(req_operator), .req_signed_mode_i(req_sm),
        .req_op_a_i(req_a), .req_op_b_i(req_b), .req_halt_i(req_halt), .req_kill_i(req_kill),
        .req_ready_i(req_ready), .req_ready_o(rr_rdy), .req_valid_o(rr_vld), .req_result_o(rr_res),
        .mul_valid_o(rr_mv), .mul_operator_o(rr_mop), .mul_signed_mode_o(rr_msm),
        .mul_op_a_o(rr_ma), .mul_op_b_o(rr_mb), .mul_halt_o(rr_mh), .mul_kill_o(rr_mk),
        .mul_ready_o(rr_mr), .mul_ready_i(rr_m[32]), .mul_valid_i(rr_m[33]), .mul_result_i(rr_m[31:0])
    );

    cv32e40x_mul_arbiter #(.RR_EN(1'b0)) u_dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_operator_i(req_operator), .req_signed_mode_i(req_sm),
        .req_op_a_i(req_a), .req_op_b_i(req_b), .req_halt_i(req_halt), .req_kill_i(req_kill),
        .req_ready_i(req_ready), .req_ready_o(fp_rdy), .req_valid_o(fp_vld), .req_result_o(fp_res),
        .mul_valid_o(fp_mv), .mul_operator_o(fp_mop), .mul_signed_mode_o(fp_msm),
        .mul_op_a_o(fp_ma), .mul_op_b_o(fp_mb), .mul_halt_o(fp_mh), .mul_kill_o(fp_mk),
        .mul_ready_o(fp_mr), .mul_ready_i(fp_m[32]), .mul_valid_i(fp_m[33]), .mul_result_i(fp_m[31:0])
    );

    // Multiplier model: MUL answers in the same cycle, MULH after four cycles; returns {valid, ready, result}
    function automatic logic [33:0] mult_model(input logic v, input mul_opcode_e op, input logic [1:0] sm,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic h, input logic k, input logic r,
                                               input logic [1:0] cnt);
        logic [63:0] pa, pb, p;
        logic        vo, ro;
        logic [31:0] res;
        pa = {{32{sm[0] & a[31]}}, a};
        pb = {{32{sm[1] & b[31]}}, b};
        p  = pa * pb;
        if (op == MUL_M32) begin
            vo  = v;
            res = p[31:0];
        end else begin
            vo  = v && (cnt == 2'd3);
            res = p[63:32];
        end
        ro = vo && r && !h;
        if (k) begin
            vo = 1'b0;
            ro = 1'b1;
        end
        return {vo, ro, res};
    endfunction

    always_comb rr_m = mult_model(rr_mv, rr_mop, rr_msm, rr_ma, rr_mb, rr_mh, rr_mk, rr_mr, rr_cnt);
    always_comb fp_m = mult_model(fp_mv, fp_mop, fp_msm, fp_ma, fp_mb, fp_mh, fp_mk, fp_mr, fp_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_cnt <= '0;
            fp_cnt <= '0;
        end else begin
            if (rr_mk) rr_cnt <= '0;
            else if (rr_mv && rr_mop == MUL_H && !rr_mh) begin
                if (rr_cnt != 2'd3) rr_cnt <= rr_cnt + 2'd1;
                else if (rr_mr)     rr_cnt <= '0;
            end
            if (fp_mk) fp_cnt <= '0;
            else if (fp_mv && fp_mop == MUL_H && !fp_mh) begin
                if (fp_cnt != 2'd3) fp_cnt <= fp_cnt + 2'd1;
                else if (fp_mr)     fp_cnt <= '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input mul_opcode_e op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b);
        req_valid[i]    = 1'b1;
        req_operator[i] = op;
        req_sm[i]       = sm;
        req_a[i]        = a;
        req_b[i]        = b;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
        req_a[i]     = '0;
        req_b[i]     = '0;
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_operator = {MUL_M32, MUL_M32};
        req_sm       = '0;
        req_a        = '0;
        req_b        = '0;
        req_halt     = '0;
        req_kill     = '0;
        req_ready    = 2'b11;

        @(negedge clk);
        chk("rst_req_valid", rr_vld, 2'b00);
        chk("rst_req_ready", rr_rdy, 2'b00);
        chk("rst_mul_valid", rr_mv, 1'b0);
        chk("rst_mul_kill", rr_mk, 1'b0);
        chk("rst_fp_req_ready", fp_rdy, 2'b00);
        rst_n = 1'b1;
        tick();

        // Simultaneous single-cycle MULs: requester 0 first, requester 1 next cycle
        set_req(0, MUL_M32, 2'b00, 32'd3, 32'd5);
        set_req(1, MUL_M32, 2'b00, 32'd7, 32'd9);
        @(negedge clk);
        chk("t1_c0_ready", rr_rdy, 2'b01);
        chk("t1_c0_valid", rr_vld, 2'b01);
        chk("t1_c0_res", rr_res[0], 32'd15);
        tick();
        clr_req(0);
        @(negedge clk);
        chk("t1_c1_ready", rr_rdy, 2'b10);
        chk("t1_c1_valid", rr_vld, 2'b10);
        chk("t1_c1_res", rr_res[1], 32'd63);
        tick();
        clr_req(1);

        // MULH owned by requester 1 blocks a later MUL from requester 0
        set_req(1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000);
        @(negedge clk);
        chk("t2_c0_mul_valid", rr_mv, 1'b1);
        chk("t2_c0_valid", rr_vld, 2'b00);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) set_req(0, MUL_M32, 2'b00, 32'd4, 32'd4);
            @(negedge clk);
            chk($sformatf("t2_c%0d_ready0", c), rr_rdy[0], 1'b0);
            chk($sformatf("t2_c%0d_valid", c), rr_vld, (c == 3) ? 2'b10 : 2'b00);
        end
        chk("t2_c3_res", rr_res[1], 32'h4000_0000);
        tick();
        clr_req(1);
        @(negedge clk);
        chk("t2_c4_ready", rr_rdy, 2'b01);
        chk("t2_c4_res", rr_res[0], 32'd16);
        tick();
        clr_req(0);

        // Owner killed mid-MULHU; the waiting MUL then runs clean
        set_req(0, MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        set_req(1, MUL_M32, 2'b00, 32'd2, 32'd2);
        @(negedge clk);
        chk("t3_c1_ready1", rr_rdy[1], 1'b0);
        tick();
        req_kill[0] = 1'b1;
        @(negedge clk);
        chk("t3_c2_mul_kill", rr_mk, 1'b1);
        chk("t3_c2_ready", rr_rdy, 2'b01);
        tick();
        req_kill[0] = 1'b0;
        clr_req(0);
        @(negedge clk);
        chk("t3_c3_ready", rr_rdy, 2'b10);
        chk("t3_c3_valid", rr_vld, 2'b10);
        chk("t3_c3_res", rr_res[1], 32'd4);
        tick();
        clr_req(1);

        // Owner halted for five cycles in the middle of a MULHU
        set_req(0, MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        req_halt[0] = 1'b1;
        set_req(1, MUL_M32, 2'b00, 32'd5, 32'd5);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4_c%0d_halt", c), rr_mh, 1'b1);
            chk($sformatf("t4_c%0d_ready", c), rr_rdy, 2'b00);
            tick();
        end
        req_halt[0] = 1'b0;
        for (int c = 6; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("t4_c%0d_valid", c), rr_vld, 2'b00);
            tick();
        end
        @(negedge clk);
        chk("t4_c8_valid", rr_vld, 2'b01);
        chk("t4_c8_ready", rr_rdy, 2'b01);
        chk("t4_c8_res", rr_res[0], 32'hFFFF_FFFE);
        tick();
        clr_req(0);
        @(negedge clk);
        chk("t4_c9_ready", rr_rdy, 2'b10);
        chk("t4_c9_res", rr_res[1], 32'd25);
        tick();
        clr_req(1);

        // Back-to-back MULs from requester 0 with requester 1 waiting
        set_req(1, MUL_M32, 2'b00, 32'd100, 32'd2);
        for (int c = 0; c < 10; c++) begin
            set_req(0, MUL_M32, 2'b00, 32'(c), 32'd3);
            @(negedge clk);
            chk($sformatf("t5_c%0d_fp_ready", c), fp_rdy, 2'b01);
            chk($sformatf("t5_c%0d_fp_res", c), fp_res[0], 64'(c * 3));
            if (c == 0) chk("t5_c0_rr_ready", rr_rdy, 2'b01);
            if (c == 1) chk("t5_c1_rr_ready", rr_rdy, 2'b10);
            tick();
        end
        clr_req(0);
        @(negedge clk);
        chk("t5_c10_fp_ready", fp_rdy, 2'b10);
        chk("t5_c10_fp_res", fp_res[1], 32'd200);
        tick();
        clr_req(1);

        // Requester not ready for the result: result held and arbiter stays busy
        req_ready[0] = 1'b0;
        set_req(0, MUL_M32, 2'b00, 32'd6, 32'd7);
        set_req(1, MUL_M32, 2'b00, 32'd1, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t6_c%0d_valid", c), rr_vld, 2'b01);
            chk($sformatf("t6_c%0d_ready", c), rr_rdy, 2'b00);
            chk($sformatf("t6_c%0d_res", c), rr_res[0], 32'd42);
            tick();
        end
        req_ready[0] = 1'b1;
        @(negedge clk);
        chk("t6_c3_ready", rr_rdy, 2'b01);
        tick();
        clr_req(0);
        @(negedge clk);
        chk("t6_c4_ready", rr_rdy, 2'b10);
        chk("t6_c4_res", rr_res[1], 32'd1);
        tick();
        clr_req(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
